aes_encipher_block: RTL

- Iterative AES encipher datapath; counterpart of the decipher block, and instantiated beside it in the AES core.
- Runs the initial AddRoundKey, the main rounds (SubBytes, ShiftRows, MixColumns, AddRoundKey) and the final round (no MixColumns).
- Round keys come one per round from the key memory, indexed by the `round` output.
- SubBytes uses a shared external 32-bit S-box (one word per cycle) through the sboxw/new_sboxw ports.

---
 rtl/aes_encipher_block.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_encipher_block.sv
// Iterative AES-128/256 encipher datapath: round 0 key add, then SubBytes/ShiftRows/MixColumns/AddRoundKey rounds.
// Optional: define AES_ENC_PARALLEL_SBOX_EN to substitute all four words in one cycle with internal S-boxes.

`ifdef AES_ENC_PARALLEL_SBOX_EN
module aes_sbox (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      else      p = p;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), followed by the affine transform.
  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign word_out = {sbox_byte(word_in[31:24]), sbox_byte(word_in[23:16]),
                     sbox_byte(word_in[15:8]),  sbox_byte(word_in[7:0])};

endmodule
`endif

module aes_encipher_block (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    SBOX = 2'd2,
    MAIN = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   round_ctr_q, round_ctr_d;
  logic [1:0]   sword_ctr_q, sword_ctr_d;
  logic         keylen_q, keylen_d;
  logic         ready_q, ready_d;
  logic [127:0] block_q, block_d;

  logic [3:0]   num_rounds;
  logic         more_rounds;
  logic [127:0] shifted;
  logic [127:0] mixed;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_word(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_word(s[127:96]), mix_word(s[95:64]), mix_word(s[63:32]), mix_word(s[31:0])};
  endfunction

  // Byte r of output word i comes from byte r of input word (i+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 4; b++) begin
        r[127 - 32*w - 8*b -: 8] = s[127 - 32*((w + b) % 4) - 8*b -: 8];
      end
    end
    return r;
  endfunction

  assign num_rounds  = keylen_q ? 4'he : 4'ha;
  assign more_rounds = (round_ctr_q < num_rounds);
  assign shifted     = shift_rows(block_q);
  assign mixed       = mix_columns(shifted);

`ifdef AES_ENC_PARALLEL_SBOX_EN
  logic [127:0] sub_block;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .word_in  (block_q[32*g +: 32]),
      .word_out (sub_block[32*g +: 32])
    );
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      round_ctr_q <= 4'h0;
      sword_ctr_q <= 2'd0;
      keylen_q    <= 1'b0;
      ready_q     <= 1'b1;
      block_q     <= 128'h0;
    end else begin
      state_q     <= state_d;
      round_ctr_q <= round_ctr_d;
      sword_ctr_q <= sword_ctr_d;
      keylen_q    <= keylen_d;
      ready_q     <= ready_d;
      block_q     <= block_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = next ? INIT : IDLE;
      INIT: state_d = SBOX;
`ifdef AES_ENC_PARALLEL_SBOX_EN
      SBOX: state_d = MAIN;
`else
      SBOX: state_d = (sword_ctr_q == 2'd3) ? MAIN : SBOX;
`endif
      MAIN: state_d = more_rounds ? SBOX : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    round_ctr_d = round_ctr_q;
    sword_ctr_d = sword_ctr_q;
    keylen_d    = keylen_q;
    ready_d     = ready_q;
    block_d     = block_q;
    sboxw       = 32'h0;
    case (state_q)
      IDLE: begin
        if (next) begin
          round_ctr_d = 4'h0;
          keylen_d    = keylen;
          ready_d     = 1'b0;
        end else begin
          ready_d     = ready_q;
        end
      end
      INIT: begin
        block_d     = block ^ round_key;
        round_ctr_d = 4'h1;
        sword_ctr_d = 2'd0;
      end
      SBOX: begin
`ifdef AES_ENC_PARALLEL_SBOX_EN
        block_d     = sub_block;
        sword_ctr_d = 2'd0;
`else
        // The shared S-box returns its result combinationally in the same cycle.
        case (sword_ctr_q)
          2'd0: begin sboxw = block_q[127:96]; block_d[127:96] = new_sboxw; end
          2'd1: begin sboxw = block_q[95:64];  block_d[95:64]  = new_sboxw; end
          2'd2: begin sboxw = block_q[63:32];  block_d[63:32]  = new_sboxw; end
          2'd3: begin sboxw = block_q[31:0];   block_d[31:0]   = new_sboxw; end
          default: sboxw = 32'h0;
        endcase
        sword_ctr_d = sword_ctr_q + 2'd1;
`endif
      end
      MAIN: begin
        if (more_rounds) begin
          block_d     = mixed ^ round_key;
          round_ctr_d = round_ctr_q + 4'h1;
          sword_ctr_d = 2'd0;
        end else begin
          block_d     = shifted ^ round_key;
          ready_d     = 1'b1;
        end
      end
      default: begin
        ready_d = ready_q;
      end
    endcase
  end

  assign round     = round_ctr_q;
  assign new_block = block_q;
  assign ready     = ready_q;

endmodule
